// File: rtl/keypad_led_pkg.sv
// Shared types and the key-code to LED-index mapping for the keypad LED sequencer.
// Keys are numbered row-major on the pad, but the LEDs are wired column-major.
package keypad_led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    // Returns -1 for codes that do not name a key (0 or beyond the pad).
    function automatic int key_to_index(input int code, input int rows, input int cols);
        if (code < 1 || code > rows * cols) begin
            return -1;
        end
        return ((code - 1) % cols) * rows + (code - 1) / cols;
    endfunction

endpackage

// File: rtl/keypad_led_map.sv
// Combinational key-code to one-hot LED decoder; unmapped codes decode to all-off.
module keypad_led_map
    import keypad_led_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 3,
    parameter int CODE_W = 4
) (
    input  logic [CODE_W-1:0]    code,
    output logic [ROWS*COLS-1:0] onehot
);

    // The mapping is a bijection, so every LED bit is driven by exactly one key.
    for (genvar k = 1; k <= ROWS * COLS; k++) begin : g_key
        localparam int BIT = key_to_index(k, ROWS, COLS);
        assign onehot[BIT] = (32'(code) == 32'(k));
    end

endmodule

// File: rtl/keypad_led_sequencer.sv
// Keypad code buffer with a static OR display and a timed step/gap playback.
// Optional build macro KEYPAD_LED_BLINK_EN makes the idle display blink.
//
// state | meaning
// IDLE  | static display of all stored codes; writes and start accepted
// STEP  | one stored code lit for STEP_CYCLES
// GAP   | all LEDs off for GAP_CYCLES between steps
module keypad_led_sequencer
    import keypad_led_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 3,
    parameter int CODE_W      = 4,
    parameter int DEPTH       = 12,
    parameter int STEP_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000
`ifdef KEYPAD_LED_BLINK_EN
    ,
    parameter int BLINK_CYCLES = 12500000
`endif
) (
    input  logic                         CLOCK_50,
    input  logic                         Reset,
    input  logic                         clear,
    input  logic                         wr_valid,
    input  logic [CODE_W-1:0]            wr_code,
    output logic                         wr_ready,
    input  logic                         mode,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [ROWS*COLS-1:0]         led
);

    localparam int NUM_KEYS = ROWS * COLS;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] STEP_LOAD = 32'(STEP_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

    seq_state_t          state, state_next;
    logic [31:0]         timer, timer_next;
    logic [IDX_W-1:0]    index, index_next;
    logic                done_next;
    logic [NUM_KEYS-1:0] led_next;
    logic [NUM_KEYS-1:0] static_pat, static_disp, step_hot;
    logic [CODE_W-1:0]   buffer [DEPTH];
    logic [NUM_KEYS-1:0] entry_hot [DEPTH];
    logic [DEPTH-1:0]    entry_valid;
    logic                wr_accept, last_entry, launch;

    assign wr_ready   = (count < CNT_W'(DEPTH)) && (state == IDLE) && !clear;
    assign wr_accept  = wr_valid && wr_ready;
    assign busy       = (state != IDLE);
    assign last_entry = ((CNT_W'(index) + CNT_W'(1)) == count);
    // A write in the start cycle counts, so an empty buffer can still launch.
    assign launch     = start && mode && ((count != '0) || wr_accept);

    // Storage is never reset: entries at or beyond count are never displayed.
    always_ff @(posedge CLOCK_50) begin
        if (wr_accept) begin
            buffer[count[IDX_W-1:0]] <= wr_code;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        keypad_led_map #(
            .ROWS   (ROWS),
            .COLS   (COLS),
            .CODE_W (CODE_W)
        ) u_map (
            .code   (buffer[i]),
            .onehot (entry_hot[i])
        );
        assign entry_valid[i] = (count > CNT_W'(i));
    end

    always_comb begin
        static_pat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                static_pat = static_pat | entry_hot[i];
            end
        end
    end

    keypad_led_map #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .CODE_W (CODE_W)
    ) u_step_map (
        .code   (buffer[index]),
        .onehot (step_hot)
    );

`ifdef KEYPAD_LED_BLINK_EN
    localparam logic [31:0] BLINK_LOAD = 32'(BLINK_CYCLES - 1);

    logic [31:0] blink_timer;
    logic        blink_on;

    always_ff @(posedge CLOCK_50) begin
        if (!Reset || clear) begin
            blink_timer <= BLINK_LOAD;
            blink_on    <= 1'b1;
        end else if (blink_timer == '0) begin
            blink_timer <= BLINK_LOAD;
            blink_on    <= ~blink_on;
        end else begin
            blink_timer <= blink_timer - 32'd1;
        end
    end

    assign static_disp = blink_on ? static_pat : '0;
`else
    assign static_disp = static_pat;
`endif

    always_comb begin
        state_next = state;
        timer_next = timer;
        index_next = index;
        done_next  = 1'b0;
        led_next   = '0;

        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    led_next = static_disp;
                    if (launch) begin
                        state_next = STEP;
                        timer_next = STEP_LOAD;
                        index_next = '0;
                    end
                end
                STEP: begin
                    led_next = step_hot;
                    if (timer != '0) begin
                        timer_next = timer - 32'd1;
                    end else if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        timer_next = GAP_LOAD;
                    end else if (last_entry) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        index_next = index + IDX_W'(1);
                        timer_next = STEP_LOAD;
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer_next = timer - 32'd1;
                    end else if (last_entry) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = STEP;
                        index_next = index + IDX_W'(1);
                        timer_next = STEP_LOAD;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            state <= IDLE;
            timer <= '0;
            index <= '0;
            done  <= 1'b0;
            led   <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            index <= index_next;
            done  <= done_next;
            led   <= led_next;
            if (clear) begin
                count <= '0;
            end else if (wr_accept) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_keypad_led_sequencer.sv
// Self-checking bench for keypad_led_sequencer: directed table, playback sequences,
// and randomized traffic against a frame-queue reference model.
module tb_keypad_led_sequencer;

    localparam int ROWS   = 4;
    localparam int COLS   = 3;
    localparam int CODE_W = 4;
    localparam int DEPTH  = 12;
    localparam int STEP   = 3;
    localparam int GAP    = 2;
    localparam int NK     = ROWS * COLS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              wr_valid;
    logic [CODE_W-1:0] wr_code;
    logic              wr_ready;
    logic              mode;
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        count;
    logic [NK-1:0]     led;

    always #5 clk = ~clk;

    keypad_led_sequencer #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .CODE_W      (CODE_W),
        .DEPTH       (DEPTH),
        .STEP_CYCLES (STEP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (rst_n),
        .clear    (clear),
        .wr_valid (wr_valid),
        .wr_code  (wr_code),
        .wr_ready (wr_ready),
        .mode     (mode),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .led      (led)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of stored codes plus a queue of pending playback frames.
    int m_buf[DEPTH];
    int m_count = 0;
    int m_q[$];
    int m_led  = 0;
    int m_done = 0;

    function automatic int key_mask(input int code);
        int row, col;
        if (code < 1 || code > NK) return 0;
        row = (code - 1) / COLS;
        col = (code - 1) % COLS;
        return 1 << (col * ROWS + row);
    endfunction

    function automatic int static_mask();
        int m = 0;
        for (int i = 0; i < m_count; i++) m |= key_mask(m_buf[i]);
        return m;
    endfunction

    task automatic model_edge();
        if (!rst_n || clear) begin
            m_count = 0;
            m_q.delete();
            m_led  = 0;
            m_done = 0;
        end else if (m_q.size() > 0) begin
            m_led  = m_q.pop_front();
            m_done = (m_q.size() == 0);
        end else begin
            m_led  = static_mask();
            m_done = 0;
            if (wr_valid && m_count < DEPTH) begin
                m_buf[m_count] = int'(wr_code);
                m_count++;
            end
            if (start && mode && m_count > 0) begin
                for (int i = 0; i < m_count; i++) begin
                    for (int s = 0; s < STEP; s++) m_q.push_back(key_mask(m_buf[i]));
                    for (int g = 0; g < GAP; g++) m_q.push_back(0);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_count", 32'(count), 32'(m_count));
        chk("model_led", 32'(led), 32'(m_led));
        chk("model_busy", 32'(busy), 32'(m_q.size() > 0));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_wr_ready", 32'(wr_ready),
            32'((m_count < DEPTH) && (m_q.size() == 0) && !clear));
    endtask

    task automatic idle_inputs();
        clear = 1'b0; wr_valid = 1'b0; wr_code = '0; start = 1'b0; mode = 1'b1;
    endtask

    typedef struct {
        bit clr;
        bit wv;
        int code;
        bit st;
        bit md;
        int e_count;
        int e_led;
        bit e_ready;
        bit e_busy;
    } vec_t;

    vec_t tbl[12];
    int   exp_play[10];

    initial begin
        tbl[0]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1, 'h000, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1,  5, 1'b0, 1'b0, 2, 'h001, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 12, 1'b0, 1'b0, 3, 'h021, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0,  0, 1'b0, 1'b0, 3, 'h821, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1,  0, 1'b0, 1'b0, 4, 'h821, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 13, 1'b0, 1'b0, 5, 'h821, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 5, 'h821, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0,  0, 1'b0, 1'b0, 0, 'h000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0,  0, 1'b0, 1'b0, 0, 'h000, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0,  0, 1'b1, 1'b1, 0, 'h000, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1,  3, 1'b0, 1'b1, 1, 'h000, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0,  0, 1'b0, 1'b1, 1, 'h100, 1'b1, 1'b0};
        exp_play = '{'h010, 'h010, 'h010, 0, 0, 'h004, 'h004, 'h004, 0, 0};

        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_led", 32'(led), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_wr_ready", 32'(wr_ready), 1);

        // Directed table: static display, mapping, ignored starts, clear.
        for (int i = 0; i < 12; i++) begin
            clear    = tbl[i].clr;
            wr_valid = tbl[i].wv;
            wr_code  = CODE_W'(tbl[i].code);
            start    = tbl[i].st;
            mode     = tbl[i].md;
            tick();
            chk("tbl_count", 32'(count), 32'(tbl[i].e_count));
            chk("tbl_led", 32'(led), 32'(tbl[i].e_led));
            chk("tbl_wr_ready", 32'(wr_ready), 32'(tbl[i].e_ready));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
            chk("tbl_done", 32'(done), 0);
        end
        idle_inputs();

        // Fill past capacity.
        clear = 1'b1; tick(); clear = 1'b0;
        for (int n = 0; n < 13; n++) begin
            wr_valid = 1'b1;
            wr_code  = CODE_W'(n % 15 + 1);
            tick();
        end
        chk("full_count", 32'(count), 12);
        chk("full_wr_ready", 32'(wr_ready), 0);
        idle_inputs();

        // Playback of codes 2 and 7, with a mode change and a write attempt mid-run.
        clear = 1'b1; tick(); clear = 1'b0;
        wr_valid = 1'b1; wr_code = 4'd2; tick();
        wr_code = 4'd7; tick();
        wr_valid = 1'b0; tick();
        start = 1'b1; mode = 1'b1; tick();
        start = 1'b0;
        chk("play_busy", 32'(busy), 1);
        for (int k = 0; k < 10; k++) begin
            mode     = (k < 3);
            wr_valid = (k == 4);
            wr_code  = 4'd9;
            tick();
            chk("play_led", 32'(led), 32'(exp_play[k]));
            chk("play_done", 32'(done), 32'(k == 9));
        end
        idle_inputs();
        tick();
        chk("post_led", 32'(led), 'h014);
        chk("post_done", 32'(done), 0);
        chk("post_count", 32'(count), 2);

        // Clear during the second step: no done pulse afterwards.
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        clear = 1'b1; tick();
        chk("clr_busy", 32'(busy), 0);
        chk("clr_count", 32'(count), 0);
        chk("clr_led", 32'(led), 0);
        clear = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("clr_no_done", 32'(done), 0);
        end

        // Write and start in the same cycle: the new code joins the playback.
        wr_valid = 1'b1; wr_code = 4'd2; tick();
        wr_code = 4'd9; start = 1'b1; tick();
        idle_inputs();
        chk("ws_count", 32'(count), 2);
        chk("ws_busy", 32'(busy), 1);
        for (int k = 0; k < 6; k++) tick();
        chk("ws_second_led", 32'(led), 'h400);
        for (int k = 0; k < 6; k++) tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            clear    = ($urandom_range(0, 99) < 3);
            wr_valid = ($urandom_range(0, 99) < 40);
            wr_code  = CODE_W'($urandom_range(0, 15));
            start    = ($urandom_range(0, 99) < 8);
            mode     = ($urandom_range(0, 99) < 75);
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
